// File: rtl/bp_cce_mem_credit_ctrl.sv
// Credit-based flow control between the CCE memory-command port and the outbound command FIFO,
// with a drain/quiesce handshake. Optional stall statistics: define BP_CCE_CREDIT_STATS_EN.
module bp_cce_mem_credit_ctrl #(
    parameter int credits_p = 8,
    localparam int lg_credits_lp = $clog2(credits_p + 1)
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic                     mem_cmd_v_i,
    output logic                     mem_cmd_ready_o,
    output logic                     mem_cmd_v_o,
    input  logic                     mem_cmd_ready_i,
    input  logic                     mem_resp_yumi_i,
    input  logic                     drain_req_i,
    output logic                     drain_done_o,
    output logic [lg_credits_lp-1:0] outstanding_o,
    output logic                     credit_err_o,
    output logic [31:0]              stall_cnt_o,
    output logic [1:0]               state_o
);

    typedef enum logic [1:0] {
        e_run      = 2'd0,
        e_drain    = 2'd1,
        e_quiesced = 2'd2
    } state_e;

    localparam logic [lg_credits_lp-1:0] credit_limit_lp = lg_credits_lp'(credits_p);

    state_e                   state_r, state_n;
    logic [lg_credits_lp-1:0] outstanding_r, outstanding_n;
    logic                     credit_err_r;
    logic                     gate, send, ret;

    // Handshake: a command transfers on a cycle where mem_cmd_v_o and mem_cmd_ready_i are both high.
    // The gate masks valid and ready alike, so neither side sees a transfer while issue is blocked.
    assign gate            = (state_r == e_run) && (outstanding_r < credit_limit_lp);
    assign mem_cmd_v_o     = mem_cmd_v_i & gate;
    assign mem_cmd_ready_o = mem_cmd_ready_i & gate;

    assign send = mem_cmd_v_o & mem_cmd_ready_i;
    assign ret  = mem_resp_yumi_i & (outstanding_r != '0);

    always_comb begin
        outstanding_n = outstanding_r;
        if (send && !ret) begin
            outstanding_n = outstanding_r + 1'b1;
        end else if (ret && !send) begin
            outstanding_n = outstanding_r - 1'b1;
        end
    end

    // Quiescence looks at the post-update count so a final return completes the drain on its own edge.
    always_comb begin
        state_n = state_r;
        case (state_r)
            e_run:      if (drain_req_i) state_n = e_drain;
            e_drain: begin
                if (!drain_req_i) begin
                    state_n = e_run;
                end else if (outstanding_n == '0) begin
                    state_n = e_quiesced;
                end
            end
            e_quiesced: if (!drain_req_i) state_n = e_run;
            default:    state_n = e_run;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r       <= e_run;
            outstanding_r <= '0;
            credit_err_r  <= 1'b0;
        end else begin
            state_r       <= state_n;
            outstanding_r <= outstanding_n;
            if (mem_resp_yumi_i && (outstanding_r == '0)) begin
                credit_err_r <= 1'b1;
            end
        end
    end

    assign drain_done_o  = (state_r == e_quiesced);
    assign outstanding_o = outstanding_r;
    assign credit_err_o  = credit_err_r;
    assign state_o       = state_r;

`ifdef BP_CCE_CREDIT_STATS_EN
    logic [31:0] stall_cnt_r;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            stall_cnt_r <= '0;
        end else if (mem_cmd_v_i && (state_r == e_run) && (outstanding_r == credit_limit_lp)
                     && (stall_cnt_r != '1)) begin
            stall_cnt_r <= stall_cnt_r + 32'd1;
        end
    end

    assign stall_cnt_o = stall_cnt_r;
`else
    assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_bp_cce_mem_credit_ctrl.sv
// Self-checking bench for bp_cce_mem_credit_ctrl (credits_p = 4): directed vector table,
// reset/stats sequences, and random traffic against a behavioural model.
module tb_bp_cce_mem_credit_ctrl;

    localparam int CRED = 4;
    localparam int LGW  = $clog2(CRED + 1);
    localparam int M_RUN = 0, M_DRAIN = 1, M_QUIET = 2;

    logic           clk_i = 1'b0;
    logic           reset_n_i;
    logic           mem_cmd_v_i, mem_cmd_ready_i, mem_resp_yumi_i, drain_req_i;
    logic           mem_cmd_ready_o, mem_cmd_v_o, drain_done_o, credit_err_o;
    logic [LGW-1:0] outstanding_o;
    logic [31:0]    stall_cnt_o;
    logic [1:0]     state_o;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state
    int          m_out, m_st;
    logic        m_err;
    logic [31:0] m_stall;

    bp_cce_mem_credit_ctrl #(.credits_p(CRED)) dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i),
        .mem_cmd_v_i(mem_cmd_v_i), .mem_cmd_ready_o(mem_cmd_ready_o),
        .mem_cmd_v_o(mem_cmd_v_o), .mem_cmd_ready_i(mem_cmd_ready_i),
        .mem_resp_yumi_i(mem_resp_yumi_i), .drain_req_i(drain_req_i),
        .drain_done_o(drain_done_o), .outstanding_o(outstanding_o),
        .credit_err_o(credit_err_o), .stall_cnt_o(stall_cnt_o), .state_o(state_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_out = 0; m_st = M_RUN; m_err = 1'b0; m_stall = 0;
    endtask

    // Drive inputs on the falling edge and let combinational outputs settle.
    task automatic apply(input logic v, input logic rdy, input logic yumi, input logic drain);
        @(negedge clk_i);
        mem_cmd_v_i = v; mem_cmd_ready_i = rdy; mem_resp_yumi_i = yumi; drain_req_i = drain;
        #1;
    endtask

    // Compare current outputs with the model, then advance the model across the next rising edge.
    task automatic model_step();
        logic open, send, ret;
        int   nxt;
        open = (m_st == M_RUN) && (m_out < CRED);
        chk("mem_cmd_v_o", 32'(mem_cmd_v_o), 32'(mem_cmd_v_i && open));
        chk("mem_cmd_ready_o", 32'(mem_cmd_ready_o), 32'(mem_cmd_ready_i && open));
        chk("outstanding_o", 32'(outstanding_o), 32'(m_out));
        chk("drain_done_o", 32'(drain_done_o), 32'(m_st == M_QUIET));
        chk("credit_err_o", 32'(credit_err_o), 32'(m_err));
`ifdef BP_CCE_CREDIT_STATS_EN
        chk("stall_cnt_o", stall_cnt_o, m_stall);
`else
        chk("stall_cnt_o", stall_cnt_o, 32'd0);
`endif
        send = mem_cmd_v_i && open && mem_cmd_ready_i;
        ret  = mem_resp_yumi_i && (m_out > 0);
        if (mem_resp_yumi_i && m_out == 0) m_err = 1'b1;
        if (mem_cmd_v_i && m_st == M_RUN && m_out == CRED && m_stall != 32'hFFFF_FFFF) m_stall++;
        nxt = m_out + (send ? 1 : 0) - (ret ? 1 : 0);
        m_out = nxt;
        case (m_st)
            M_RUN:   if (drain_req_i) m_st = M_DRAIN;
            M_DRAIN: if (!drain_req_i) m_st = M_RUN; else if (nxt == 0) m_st = M_QUIET;
            default: if (!drain_req_i) m_st = M_RUN;
        endcase
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        mem_cmd_v_i = 0; mem_cmd_ready_i = 1; mem_resp_yumi_i = 0; drain_req_i = 0;
        reset_n_i = 0;
        #1;
        chk("rst mem_cmd_v_o", 32'(mem_cmd_v_o), 0);
        chk("rst mem_cmd_ready_o", 32'(mem_cmd_ready_o), 1);
        chk("rst outstanding_o", 32'(outstanding_o), 0);
        chk("rst drain_done_o", 32'(drain_done_o), 0);
        chk("rst credit_err_o", 32'(credit_err_o), 0);
        chk("rst stall_cnt_o", stall_cnt_o, 0);
        @(negedge clk_i);
        reset_n_i = 1;
        model_reset();
    endtask

    typedef struct {
        logic v, rdy, yumi, drain;
        logic e_v, e_rdy;
        int   e_out;
        logic e_done, e_err;
    } vec_t;

    function automatic vec_t mk(input logic v, input logic rdy, input logic yumi, input logic drain,
                                input logic e_v, input logic e_rdy, input int e_out,
                                input logic e_done, input logic e_err);
        vec_t r;
        r.v = v; r.rdy = rdy; r.yumi = yumi; r.drain = drain;
        r.e_v = e_v; r.e_rdy = e_rdy; r.e_out = e_out; r.e_done = e_done; r.e_err = e_err;
        return r;
    endfunction

    vec_t tbl[22];

    initial begin
        reset_n_i = 0;
        mem_cmd_v_i = 0; mem_cmd_ready_i = 0; mem_resp_yumi_i = 0; drain_req_i = 0;
        model_reset();

        //            v  r  y  d   ev er out done err
        tbl[0]  = mk(1, 1, 0, 0,  1, 1, 0, 0, 0);  // fill
        tbl[1]  = mk(1, 1, 0, 0,  1, 1, 1, 0, 0);
        tbl[2]  = mk(1, 1, 0, 0,  1, 1, 2, 0, 0);
        tbl[3]  = mk(1, 1, 0, 0,  1, 1, 3, 0, 0);
        tbl[4]  = mk(1, 1, 0, 0,  0, 0, 4, 0, 0);  // full
        tbl[5]  = mk(1, 1, 1, 0,  0, 0, 4, 0, 0);  // return does not open gate this cycle
        tbl[6]  = mk(1, 1, 0, 0,  1, 1, 3, 0, 0);  // reissue
        tbl[7]  = mk(0, 1, 1, 0,  0, 0, 4, 0, 0);
        tbl[8]  = mk(0, 1, 1, 0,  0, 1, 3, 0, 0);
        tbl[9]  = mk(1, 1, 1, 0,  1, 1, 2, 0, 0);  // send + return together
        tbl[10] = mk(1, 1, 0, 1,  1, 1, 2, 0, 0);  // drain requested, this send counts
        tbl[11] = mk(1, 1, 0, 1,  0, 0, 3, 0, 0);
        tbl[12] = mk(1, 1, 1, 1,  0, 0, 3, 0, 0);
        tbl[13] = mk(1, 1, 1, 1,  0, 0, 2, 0, 0);
        tbl[14] = mk(1, 1, 1, 1,  0, 0, 1, 0, 0);  // final return quiesces on its edge
        tbl[15] = mk(1, 1, 0, 1,  0, 0, 0, 1, 0);
        tbl[16] = mk(1, 1, 0, 0,  0, 0, 0, 1, 0);  // drain released
        tbl[17] = mk(1, 1, 0, 0,  1, 1, 0, 0, 0);  // sends resume
        tbl[18] = mk(0, 1, 1, 0,  0, 1, 1, 0, 0);
        tbl[19] = mk(0, 0, 1, 0,  0, 0, 0, 0, 0);  // underflow attempt
        tbl[20] = mk(0, 0, 0, 0,  0, 0, 0, 0, 1);
        tbl[21] = mk(0, 0, 0, 0,  0, 0, 0, 0, 1);

        do_reset();

        for (int i = 0; i < 22; i++) begin
            apply(tbl[i].v, tbl[i].rdy, tbl[i].yumi, tbl[i].drain);
            chk($sformatf("vec%0d v_o", i), 32'(mem_cmd_v_o), 32'(tbl[i].e_v));
            chk($sformatf("vec%0d ready_o", i), 32'(mem_cmd_ready_o), 32'(tbl[i].e_rdy));
            chk($sformatf("vec%0d outstanding", i), 32'(outstanding_o), 32'(tbl[i].e_out));
            chk($sformatf("vec%0d drain_done", i), 32'(drain_done_o), 32'(tbl[i].e_done));
            chk($sformatf("vec%0d credit_err", i), 32'(credit_err_o), 32'(tbl[i].e_err));
            model_step();
        end

        // Asynchronous reset pulse away from the clock edge clears the sticky error at once.
        apply(0, 0, 0, 0);
        reset_n_i = 0;
        #1;
        chk("async rst credit_err", 32'(credit_err_o), 0);
        chk("async rst outstanding", 32'(outstanding_o), 0);
        @(negedge clk_i);
        reset_n_i = 1;
        model_reset();

        // Stall statistics: fill, then hold valid at the limit for 10 cycles.
        for (int i = 0; i < CRED; i++) begin
            apply(1, 1, 0, 0);
            model_step();
        end
        for (int i = 0; i < 10; i++) begin
            apply(1, 1, 0, 0);
            model_step();
        end
        apply(0, 1, 0, 0);
`ifdef BP_CCE_CREDIT_STATS_EN
        chk("stall_cnt after 10", stall_cnt_o, 32'd10);
`else
        chk("stall_cnt disabled", stall_cnt_o, 32'd0);
`endif
        model_step();

        do_reset();

        // Random traffic against the model.
        begin
            logic drain_lvl = 1'b0;
            for (int i = 0; i < 600; i++) begin
                logic y;
                if ($urandom_range(0, 24) == 0) drain_lvl = ~drain_lvl;
                y = (m_out > 0) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 59) == 0);
                apply(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0), y, drain_lvl);
                model_step();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bp_cce_mem_credit_ctrl.md
# bp_cce_mem_credit_ctrl

Credit-based flow controller between the CCE's outbound memory-command port and its outbound command FIFO. It caps outstanding memory commands at the depth of the inbound memory-response FIFO, so every response always has a slot and the CCE is never blocked on a response it cannot yet sink. It also provides a drain/quiesce handshake for configuration-mode changes.

## Interface
- credits_p, default 8: maximum outstanding memory commands; set equal to the memory-response FIFO depth (lce_sets_p / num_cce_p); must be ≥1.
- lg_credits_lp, derived: `BSG_SAFE_CLOG2(credits_p+1)`; width of the credit counters.
- clk_i  in  1  clock; all state updates on the rising edge.
- reset_n_i  in  1  asynchronous, active-low reset.
- mem_cmd_v_i  in  1  command valid from the CCE.
- mem_cmd_ready_o  out  1  ready to the CCE.
- mem_cmd_v_o  out  1  valid to the outbound command FIFO.
- mem_cmd_ready_i  in  1  ready from the outbound command FIFO.
- mem_resp_yumi_i  in  1  CCE consumed one memory response; returns one credit.
- drain_req_i  in  1  level request to stop issuing and quiesce.
- drain_done_o  out  1  quiesced: no outstanding commands, issue blocked.
- outstanding_o  out  lg_credits_lp  current outstanding count.
- credit_err_o  out  1  sticky: a credit was returned while none were outstanding.
- stall_cnt_o  out  32  count of credit-exhaustion stall cycles (see Configuration).

## Operation
- States: e_run, e_drain, e_quiesced.
- Reset state is e_run.
- Issue gate: gate = (state == e_run) & (outstanding_o < credits_p).
- Outputs under the gate:
  - mem_cmd_v_o = mem_cmd_v_i & gate.
  - mem_cmd_ready_o = mem_cmd_ready_i & gate.
  - Both outputs are combinational and carry no data; the command data bypasses this block.
- Counter events:
  - send = mem_cmd_v_o & mem_cmd_ready_i.
  - ret = mem_resp_yumi_i & (outstanding_o != 0).
- Counter update on each clock edge:
  - send only: +1.
  - ret only: −1.
  - Both send and ret: unchanged.
  - Neither: unchanged.
- Credit error:
  - mem_resp_yumi_i while outstanding_o == 0 sets credit_err_o.
  - The counter does not underflow.
  - credit_err_o clears only on reset.
- State transitions:
  - e_run → e_drain when drain_req_i = 1.
  - e_drain → e_quiesced when outstanding_o == 0. This is evaluated after the current cycle's update, so a final ret moves the state on the same edge.
  - e_quiesced → e_run when drain_req_i = 0.
  - e_drain → e_run if drain_req_i drops before quiescence.
- drain_done_o = (state == e_quiesced).
- The counter never exceeds credits_p, because the gate prevents a send at the limit.

## Timing
- Reset values:
  - mem_cmd_v_o = 0.
  - mem_cmd_ready_o = mem_cmd_ready_i & 1: gate is open after reset; combinational.
  - drain_done_o = 0.
  - outstanding_o = 0.
  - credit_err_o = 0.
  - stall_cnt_o = 0.
- Zero added latency on the command path.
- A credit returned in cycle t permits a send in cycle t+1, not in cycle t.
- A drain request asserted in cycle t blocks sends from cycle t+1. A send accepted in cycle t still counts.
- A reset asserted mid-operation clears all state immediately (asynchronous). Any responses still in flight afterwards set credit_err_o; the system must reset the memory side together with this block.

## Configuration
- BP_CCE_CREDIT_STATS_EN defined: stall_cnt_o increments every cycle with mem_cmd_v_i = 1, state == e_run and outstanding_o == credits_p. It saturates at 2^32−1.
- BP_CCE_CREDIT_STATS_EN undefined: the counter logic is not compiled; stall_cnt_o is tied to 0.

## Test plan
- Fill: credits_p = 4, mem_cmd_v_i and mem_cmd_ready_i held at 1 → exactly 4 sends on consecutive cycles; outstanding_o = 4; mem_cmd_ready_o = 0 from cycle 4.
- Return and reissue: at outstanding 4, pulse mem_resp_yumi_i once → outstanding 3 next cycle; one send allowed the following cycle; outstanding back to 4.
- Simultaneous events: at outstanding 2, send and mem_resp_yumi_i in the same cycle → outstanding stays 2; no error.
- Drain: at outstanding 3, assert drain_req_i → no further sends; after 3 returns, drain_done_o = 1 on the edge of the third return. Deassert drain_req_i → state e_run and sends resume the next cycle.
- Underflow: mem_resp_yumi_i at outstanding 0 → credit_err_o = 1 and sticky; outstanding stays 0; an asynchronous reset_n_i pulse clears it.
- Stats: with the macro defined, hold v = 1 at the full limit for 10 cycles → stall_cnt_o = 10. Without the macro → stall_cnt_o = 0.
